id_stage: RTL and testbench

- Instruction-decode pipeline stage that sits directly upstream of the 8x16 register file.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and drives the register file read addresses.
- Captures the read data, immediate and control bits into an ID/EX register that feeds execute over a second valid/ready handshake.
- Keeps a scoreboard of pending register writes and stalls on read-after-write hazards.

---
 rtl/id_stage_if.sv | 71 +++++++
 rtl/id_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// id_stage_if: signal bundle around the instruction-decode stage.
//   Fetch side   : in_valid, in_ready, in_instr, flush
//   Register file: rf_a1, rf_a2 (read addresses), rf_rd1, rf_rd2 (read data)
//   Writeback    : wb_valid, wb_dest
//   Execute side : out_valid, out_ready, out_opa, out_opb, out_imm,
//                  out_aluop, out_use_imm, out_mem_rd, out_mem_wr,
//                  out_branch, out_reg_wr, out_dest
//   With ILLEGAL_OP_EN defined: out_illegal, err_sticky
// Modports: slave = the decode stage itself, master = surrounding pipeline.
interface id_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic          flush;

  logic [AW-1:0] rf_a1;
  logic [AW-1:0] rf_a2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;

  logic          wb_valid;
  logic [AW-1:0] wb_dest;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_opa;
  logic [DW-1:0] out_opb;
  logic [DW-1:0] out_imm;
  logic [2:0]    out_aluop;
  logic          out_use_imm;
  logic          out_mem_rd;
  logic          out_mem_wr;
  logic          out_branch;
  logic          out_reg_wr;
  logic [AW-1:0] out_dest;
`ifdef ILLEGAL_OP_EN
  logic          out_illegal;
  logic          err_sticky;
`endif

  modport slave (
    input  in_valid, in_instr, flush,
    input  rf_rd1, rf_rd2,
    input  wb_valid, wb_dest,
    input  out_ready,
    output in_ready,
    output rf_a1, rf_a2,
    output out_valid, out_opa, out_opb, out_imm, out_aluop, out_use_imm,
    output out_mem_rd, out_mem_wr, out_branch, out_reg_wr, out_dest
`ifdef ILLEGAL_OP_EN
    , output out_illegal, err_sticky
`endif
  );

  modport master (
    output in_valid, in_instr, flush,
    output rf_rd1, rf_rd2,
    output wb_valid, wb_dest,
    output out_ready,
    input  in_ready,
    input  rf_a1, rf_a2,
    input  out_valid, out_opa, out_opb, out_imm, out_aluop, out_use_imm,
    input  out_mem_rd, out_mem_wr, out_branch, out_reg_wr, out_dest
`ifdef ILLEGAL_OP_EN
    , input out_illegal, err_sticky
`endif
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode pipeline stage in front of an 8x16 register
// file. Decodes a 16-bit instruction, drives the register file read
// addresses combinationally, captures operands/immediate/controls into the
// ID/EX register and hands it to execute over a valid/ready handshake.
// A busy-bit scoreboard of in-flight destinations stalls read-after-write
// hazards.
//
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - id_stage_if.slave (fetch, register file, writeback, execute)
//
// Instruction: op[15:12] ra[11:9] rb[8:6] rc[5:3] imm6[5:0]
//
// Optional build macro ILLEGAL_OP_EN: adds out_illegal (opcodes 9-15) and
// err_sticky (set on accepting an illegal op, cleared only by rst).
module id_stage #(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 3,
  parameter int unsigned NREG = 8
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_e;

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] imm;
    logic [2:0]    aluop;
    logic          use_imm;
    logic          mem_rd;
    logic          mem_wr;
    logic          branch;
    logic          reg_wr;
    logic [AW-1:0] dest;
`ifdef ILLEGAL_OP_EN
    logic          illegal;
`endif
  } idex_t;

  // ---------------------------------------------------------------- decode
  logic [3:0]    op;
  logic [AW-1:0] ra, rb, rc;
  logic          use1, use2, src2_is_ra, wr_op;
  idex_t         dec;

  assign op = bus.in_instr[15:12];
  assign ra = bus.in_instr[11:9];
  assign rb = bus.in_instr[8:6];
  assign rc = bus.in_instr[5:3];

  always_comb begin
    use1       = 1'b0;
    use2       = 1'b0;
    src2_is_ra = 1'b0;
    wr_op      = 1'b0;
    dec        = '0;
    case (op)
      OP_ADD:  begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; dec.aluop = ALU_ADD; end
      OP_SUB:  begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; dec.aluop = ALU_SUB; end
      OP_AND:  begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; dec.aluop = ALU_AND; end
      OP_OR:   begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; dec.aluop = ALU_OR;  end
      OP_ADDI: begin
        use1 = 1'b1; wr_op = 1'b1; dec.use_imm = 1'b1; dec.aluop = ALU_ADD;
      end
      OP_LW: begin
        use1 = 1'b1; wr_op = 1'b1; dec.use_imm = 1'b1; dec.mem_rd = 1'b1;
        dec.aluop = ALU_ADD;
      end
      OP_SW: begin
        use1 = 1'b1; use2 = 1'b1; src2_is_ra = 1'b1; dec.mem_wr = 1'b1;
        dec.aluop = ALU_ADD;
      end
      // Branch compares by subtraction in execute.
      OP_BEQ: begin
        use1 = 1'b1; use2 = 1'b1; src2_is_ra = 1'b1; dec.branch = 1'b1;
        dec.aluop = ALU_SUB;
      end
      default: ;
    endcase
    dec.opa    = bus.rf_rd1;
    dec.opb    = bus.rf_rd2;
    dec.imm    = {{(DW-6){bus.in_instr[5]}}, bus.in_instr[5:0]};
    // r0 is hard zero: a write to it is dropped at decode.
    dec.reg_wr = wr_op && (ra != '0);
    dec.dest   = dec.reg_wr ? ra : '0;
`ifdef ILLEGAL_OP_EN
    dec.illegal = (op > 4'd8);
`endif
  end

  // Read addresses follow in_instr regardless of in_valid.
  assign bus.rf_a1 = rb;
  assign bus.rf_a2 = src2_is_ra ? ra : rc;

  // ------------------------------------------------------------ state regs
  idex_t            idex_q, idex_d;
  logic             valid_q, valid_d;
  logic [NREG-1:0]  busy_q, busy_d;

  // ---------------------------------------------------------------- hazard
  logic haz1, haz2, hazard, accept, out_fire;

  // A source is clear when its pending write commits this cycle: the register
  // file writes on negedge, so rf_rd* is valid before the capturing posedge.
  always_comb begin
    haz1 = use1 && (bus.rf_a1 != '0) &&
           ((busy_q[bus.rf_a1] && !(bus.wb_valid && (bus.wb_dest == bus.rf_a1))) ||
            (valid_q && idex_q.reg_wr && (idex_q.dest == bus.rf_a1)));
    haz2 = use2 && (bus.rf_a2 != '0) &&
           ((busy_q[bus.rf_a2] && !(bus.wb_valid && (bus.wb_dest == bus.rf_a2))) ||
            (valid_q && idex_q.reg_wr && (idex_q.dest == bus.rf_a2)));
    hazard = haz1 || haz2;
  end

  assign bus.in_ready = !rst && !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // A flushed entry is killed, so it never counts as handed to execute.
  assign out_fire     = valid_q && bus.out_ready && !bus.flush;

  // ------------------------------------------------------------ scoreboard
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) busy_d[bus.wb_dest] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (out_fire && idex_q.reg_wr) busy_d[idex_q.dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // -------------------------------------------------------------- ID/EX reg
  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      idex_d  = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ILLEGAL_OP_EN
  logic err_q, err_d;

  assign err_d = err_q || (accept && dec.illegal);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.out_illegal = idex_q.illegal;
  assign bus.err_sticky  = err_q;
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.out_valid   = valid_q;
  assign bus.out_opa     = idex_q.opa;
  assign bus.out_opb     = idex_q.opb;
  assign bus.out_imm     = idex_q.imm;
  assign bus.out_aluop   = idex_q.aluop;
  assign bus.out_use_imm = idex_q.use_imm;
  assign bus.out_mem_rd  = idex_q.mem_rd;
  assign bus.out_mem_wr  = idex_q.mem_wr;
  assign bus.out_branch  = idex_q.branch;
  assign bus.out_reg_wr  = idex_q.reg_wr;
  assign bus.out_dest    = idex_q.dest;

endmodule

// File: tb/tb_id_stage.sv
`timescale 1ns/1ps
module tb_id_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.DW(DW), .AW(AW)) bus ();
  id_stage #(.DW(DW), .AW(AW), .NREG(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file model: combinational read.
  logic [15:0] regs [8];
  assign bus.rf_rd1 = regs[bus.rf_a1];
  assign bus.rf_rd2 = regs[bus.rf_a2];

  typedef struct {
    logic [15:0] opa, opb, imm;
    logic [2:0]  aluop;
    logic        use_imm, mem_rd, mem_wr, branch, reg_wr;
    logic [2:0]  dest;
    logic        illegal;
    logic        chk_ops;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    int unsigned s1, s2;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] instr, input int unsigned s1, input int unsigned s2,
                              input logic [15:0] imm, input logic [2:0] aluop,
                              input logic use_imm, input logic mem_rd, input logic mem_wr,
                              input logic branch, input logic reg_wr, input logic [2:0] dest,
                              input logic illegal, input logic chk_ops);
    vec_t v;
    v.instr = instr; v.s1 = s1; v.s2 = s2;
    v.e.opa = '0; v.e.opb = '0; v.e.imm = imm; v.e.aluop = aluop;
    v.e.use_imm = use_imm; v.e.mem_rd = mem_rd; v.e.mem_wr = mem_wr;
    v.e.branch = branch; v.e.reg_wr = reg_wr; v.e.dest = dest;
    v.e.illegal = illegal; v.e.chk_ops = chk_ops;
    return v;
  endfunction

  // Output monitor: pops expectations on every execute handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (bus.flush) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.chk_ops) begin
            check("opa", bus.out_opa, mon_e.opa);
            check("opb", bus.out_opb, mon_e.opb);
            check("imm", bus.out_imm, mon_e.imm);
          end
          check("aluop",   bus.out_aluop,   mon_e.aluop);
          check("use_imm", bus.out_use_imm, mon_e.use_imm);
          check("mem_rd",  bus.out_mem_rd,  mon_e.mem_rd);
          check("mem_wr",  bus.out_mem_wr,  mon_e.mem_wr);
          check("branch",  bus.out_branch,  mon_e.branch);
          check("reg_wr",  bus.out_reg_wr,  mon_e.reg_wr);
          check("dest",    bus.out_dest,    mon_e.dest);
`ifdef ILLEGAL_OP_EN
          check("illegal", bus.out_illegal, mon_e.illegal);
`endif
        end
      end
    end
  end

  // All stimulus tasks start shortly after a posedge.
  task automatic send(input logic [15:0] instr, input exp_t e);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0) return;
    end
    check("drain_timeout", q.size(), 32'd0);
    q.delete();
  endtask

  task automatic wb(input logic [2:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = d;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic mk_exp(input vec_t v, output exp_t e);
    e = v.e;
    e.opa = regs[v.s1];
    e.opb = regs[v.s2];
  endtask

  vec_t vecs[11];
  exp_t e;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    regs[0] = 16'h0000; regs[1] = 16'h0011; regs[2] = 16'h0005; regs[3] = 16'h0007;
    regs[4] = 16'h0044; regs[5] = 16'h0055; regs[6] = 16'h0066; regs[7] = 16'h0077;

    //            instr     s1 s2 imm       alu use rd wr br rw dest ill chk
    vecs[0]  = mk(16'h0298, 2, 3, 16'h0018, 0,  0,  0, 0, 0, 1, 1,   0,  1); // ADD r1,r2,r3
    vecs[1]  = mk(16'h1BB8, 6, 7, 16'hFFF8, 1,  0,  0, 0, 0, 1, 5,   0,  1); // SUB r5,r6,r7
    vecs[2]  = mk(16'h2728, 4, 5, 16'hFFE8, 2,  0,  0, 0, 0, 1, 3,   0,  1); // AND r3,r4,r5
    vecs[3]  = mk(16'h3E50, 1, 2, 16'h0010, 3,  0,  0, 0, 0, 1, 7,   0,  1); // OR  r7,r1,r2
    vecs[4]  = mk(16'h447F, 1, 7, 16'hFFFF, 0,  1,  0, 0, 0, 1, 2,   0,  1); // ADDI r2,r1,-1
    vecs[5]  = mk(16'h5D05, 4, 0, 16'h0005, 0,  1,  1, 0, 0, 1, 6,   0,  1); // LW r6,5(r4)
    vecs[6]  = mk(16'h66BE, 2, 3, 16'hFFFE, 0,  0,  0, 1, 0, 0, 0,   0,  1); // SW r3,-2(r2)
    vecs[7]  = mk(16'h7942, 5, 4, 16'h0002, 1,  0,  0, 0, 1, 0, 0,   0,  1); // BEQ r4,r5
    vecs[8]  = mk(16'h0050, 1, 2, 16'h0010, 0,  0,  0, 0, 0, 0, 0,   0,  1); // ADD r0,r1,r2
    vecs[9]  = mk(16'h8FFF, 0, 0, 16'h0000, 0,  0,  0, 0, 0, 0, 0,   0,  0); // NOP op 8
`ifdef ILLEGAL_OP_EN
    vecs[10] = mk(16'hA123, 0, 0, 16'h0000, 0,  0,  0, 0, 0, 0, 0,   1,  0); // op A illegal
`else
    vecs[10] = mk(16'hA123, 0, 0, 16'h0000, 0,  0,  0, 0, 0, 0, 0,   0,  0); // op A NOP
`endif

    rst = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_dest = '0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_opa", bus.out_opa, 0);
    check("rst_imm", bus.out_imm, 0);
    check("rst_reg_wr", bus.out_reg_wr, 0);
    check("rst_dest", bus.out_dest, 0);
    check("rst_busy", dut.busy_q, 0);
    check("idle_in_ready", bus.in_ready, 1);
`ifdef ILLEGAL_OP_EN
    check("rst_err_sticky", bus.err_sticky, 0);
`endif

    // Read addresses with in_valid low.
    bus.in_instr = 16'h66BE; #1;
    check("rf_a1_sw", bus.rf_a1, 2);
    check("rf_a2_sw", bus.rf_a2, 3);
    bus.in_instr = 16'h1BB8; #1;
    check("rf_a1_r", bus.rf_a1, 6);
    check("rf_a2_r", bus.rf_a2, 7);
    @(posedge clk); #1;

    // Single-instruction vectors.
    for (int i = 0; i < 11; i++) begin
      mk_exp(vecs[i], e);
      send(vecs[i].instr, e);
      drain();
      check("busy_after", dut.busy_q, vecs[i].e.reg_wr ? (32'd1 << vecs[i].e.dest) : 32'd0);
      if (vecs[i].e.reg_wr) wb(vecs[i].e.dest);
    end
`ifdef ILLEGAL_OP_EN
    check("err_sticky_set", bus.err_sticky, 1);
`endif

    // RAW hazard resolved by writeback bypass.
    mk_exp(vecs[0], e);
    send(16'h0298, e);
    bus.in_instr = 16'h0850; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_stall", bus.in_ready, 0);
      if (i == 1) check("raw_busy1", dut.busy_q, 32'h02);
      @(posedge clk); #1;
    end
    bus.wb_valid = 1'b1; bus.wb_dest = 3'd1; regs[1] = 16'h1234;
    @(negedge clk);
    check("raw_bypass_ready", bus.in_ready, 1);
    e = vecs[0].e; e.opa = 16'h1234; e.opb = regs[2]; e.imm = 16'h0010; e.dest = 3'd4;
    if (bus.in_ready) q.push_back(e);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0; bus.in_valid = 1'b0;
    drain();
    check("raw_busy4", dut.busy_q, 32'h10);
    wb(3'd4);

    // Back-pressure hold, then accept in the release cycle.
    bus.out_ready = 1'b0;
    mk_exp(vecs[3], e);
    send(16'h3E50, e);
    bus.in_instr = 16'h1B98; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_opa", bus.out_opa, 16'h1234);
      check("hold_aluop", bus.out_aluop, 3);
      check("hold_dest", bus.out_dest, 7);
      check("hold_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    e = vecs[1].e; e.opa = regs[6]; e.opb = regs[3]; e.imm = 16'h0018;
    if (bus.in_ready) q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    check("hold_busy", dut.busy_q, 32'hA0);
    wb(3'd7);
    wb(3'd5);

    // Flush with an entry held and a new instruction offered.
    bus.out_ready = 1'b0;
    mk_exp(vecs[2], e);
    send(16'h2728, e);
    bus.in_instr = 16'h447F; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_busy", dut.busy_q, 0);
    @(posedge clk); #1;
    mk_exp(vecs[4], e);
    send(16'h447F, e);
    drain();
    check("post_flush_busy", dut.busy_q, 32'h04);
    wb(3'd2);

    // Reset while an entry is stalled.
    bus.out_ready = 1'b0;
    mk_exp(vecs[0], e);
    send(16'h0298, e);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_stall_valid", bus.out_valid, 0);
    check("rst_stall_opa", bus.out_opa, 0);
    check("rst_stall_busy", dut.busy_q, 0);
`ifdef ILLEGAL_OP_EN
    check("err_sticky_clr", bus.err_sticky, 0);
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
